popcount_sequencer: RTL and testbench
=====================================

# popcount_sequencer

Multi-cycle ones-counter controller: accepts a `4*NIBBLES`-bit word on a start pulse and feeds it one nibble per clock through a 4-input ones-count encoder. The encoder maps a nibble to its 3-bit set-bit count, 0..4. The sequencer accumulates the total and reports it with a done pulse. It sits between a requesting control unit and the combinational encoder datapath, sequencing that datapath over wide operands.

## Interface
- `NIBBLES`, 4, number of 4-bit nibbles in the operand (≥1); operand width is `4*NIBBLES`.
- `CW`, 5, width of `Count`; must satisfy 2^CW > 4*NIBBLES.

- `Clock`  in  1  rising-edge clock; sole clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request; sampled only in IDLE.
- `Data`  in  4*NIBBLES  operand; captured on the edge that accepts `Start`.
- `Busy`  out  1  high while the operation is in progress (RUN).
- `Done`  out  1  one-cycle pulse; `Count` is valid.
- `Count`  out  CW  total number of set bits in the captured operand.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - operand shift register, `4*NIBBLES` bits;
  - nibble index, wide enough for `NIBBLES-1`;
  - accumulator, CW bits.
- IDLE, Start=1:
  - capture `Data` into the shift register;
  - clear accumulator and index;
  - go to RUN.
  - Start=0 → stay in IDLE.
- RUN, each cycle:
  - low nibble of the shift register drives the encoder;
  - accumulator += zero-extended 3-bit encoder result;
  - shift register shifts right by 4;
  - index increments.
  - On the cycle with index = NIBBLES-1, also go to DONE.
- DONE:
  - `Done`=1 for exactly one cycle;
  - `Count` was loaded from the final accumulator value on entry to DONE;
  - unconditional return to IDLE.
- `Count` holds its value through IDLE until the next DONE entry. It is not cleared on a new Start.
- The accumulator cannot overflow given the CW rule; no saturation logic.
- Nibble order is LSB-first. Order does not affect the result but is fixed for waveform checking.
- `Data` changes after capture have no effect on the in-flight operation.

## Timing
- Reset values: state=IDLE, `Busy`=0, `Done`=0, `Count`=0, internal registers 0.
- `Reset` overrides everything, including mid-RUN or in DONE. After the reset edge the block is in IDLE and no `Done` is produced for the aborted operation.
- Start sampled at edge E0:
  - `Busy`=1 for cycles E0..E0+NIBBLES;
  - state=DONE and `Done`=1 in the cycle after edge E0+NIBBLES;
  - `Busy`=0 in that DONE cycle.
- Latency, Start-accept edge to `Done`: NIBBLES+1 cycles (5 at default).
- Back-to-back: Start is ignored in RUN and DONE. Earliest next accept is the first IDLE cycle, giving throughput of one operation per NIBBLES+2 cycles.
- `Start` held high continuously re-triggers on each IDLE cycle. This is legal.
- `Start` and `Reset` in the same cycle: `Reset` wins; Start is dropped.
- `Done` and `Busy` are never high in the same cycle.

## Configuration
- `POPSEQ_DUAL_LANE_EN` defined:
  - two encoder instances; RUN consumes two nibbles per cycle;
  - shift by 8; accumulator adds both results;
  - RUN lasts NIBBLES/2 cycles; latency NIBBLES/2+1;
  - `NIBBLES` must be even; an odd value is a configuration error, caught by an elaboration-time check.
- Undefined: single lane exactly as described above.

## Test plan
- Reset, then Data=16'h0000 with Start pulse → `Done` 5 cycles after accept, `Count`=0, `Busy` high exactly 4 cycles.
- Data=16'hFFFF → `Count`=16 (5'b10000). Then Data=16'hA5C3 → `Count`=8. Also 16'h0001 → 1 and 16'h8000 → 1.
- Start re-asserted during RUN with Data=16'hFFFF while processing 16'h000F → ignored, `Count`=4, single `Done`; Start held high → next accept in first IDLE cycle.
- `Reset` asserted on the 2nd RUN cycle of 16'hFFFF → next cycle `Busy`=0, `Done`=0, `Count`=0, and no `Done` afterwards without a new Start.
- `Count` hold: after result 8, idle 10 cycles → `Count` stays 8, `Done` stays 0; Start and Reset in the same cycle → remains IDLE, `Count`=0.
- With `POPSEQ_DUAL_LANE_EN`, Data=16'hA5C3 → `Count`=8, `Busy` high 2 cycles, `Done` 3 cycles after accept.

Source files
------------

// File: rtl/popcount_sequencer.sv
// Multi-cycle ones counter: feeds a captured operand nibble-by-nibble (LSB first)
// through a 4-input ones-count encoder. Optional feature macro: POPSEQ_DUAL_LANE_EN.

module popcount_enc4 (
  input  logic [3:0] nibble,
  output logic [2:0] ones
);
  always_comb begin
    ones = {2'b00, nibble[0]} + {2'b00, nibble[1]} + {2'b00, nibble[2]} + {2'b00, nibble[3]};
  end
endmodule

module popcount_sequencer #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned CW      = 5
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [4*NIBBLES-1:0] Data,
  output logic                 Busy,
  output logic                 Done,
  output logic [CW-1:0]        Count
);

`ifdef POPSEQ_DUAL_LANE_EN
  localparam int unsigned LANES = 2;
`else
  localparam int unsigned LANES = 1;
`endif
  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned STEPS = NIBBLES / LANES;
  localparam int unsigned IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if ((NIBBLES % LANES) != 0) begin : g_cfg_err
      $error("popcount_sequencer: NIBBLES must be even when POPSEQ_DUAL_LANE_EN is defined");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   step_sum;
  logic [2:0]      ones0;

  popcount_enc4 u_enc0 (
    .nibble (shreg_q[3:0]),
    .ones   (ones0)
  );

`ifdef POPSEQ_DUAL_LANE_EN
  logic [2:0] ones1;

  popcount_enc4 u_enc1 (
    .nibble (shreg_q[7:4]),
    .ones   (ones1)
  );

  always_comb begin
    step_sum = CW'(ones0) + CW'(ones1);
  end
`else
  always_comb begin
    step_sum = CW'(ones0);
  end
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          shreg_d = Data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_q + step_sum;
        shreg_d = shreg_q >> (4 * LANES);
        idx_d   = idx_q + IW'(1);
        // Count takes the sum including the final step on the edge into DONE.
        if (idx_q == IW'(STEPS - 1)) begin
          count_d = acc_q + step_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign Busy  = (state_q == S_RUN);
  assign Done  = (state_q == S_DONE);
  assign Count = count_q;

endmodule

// File: tb/tb_popcount_sequencer.sv
// Self-checking bench for popcount_sequencer: vector table plus directed
// sequences for re-trigger, mid-run reset and count hold.

module tb_popcount_sequencer;

`ifdef POPSEQ_DUAL_LANE_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 4;
`endif

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] Data;
  logic        Busy;
  logic        Done;
  logic [4:0]  Count;

  int n_checks;
  int n_fail;

  popcount_sequencer #(.NIBBLES(4), .CW(5)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Data  (Data),
    .Busy  (Busy),
    .Done  (Done),
    .Count (Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start cycle is cycle 0; Done is expected in cycle STEPS+1 with Busy high STEPS cycles.
  task automatic run_op(input logic [15:0] d, input logic [4:0] exp, input string name);
    int  busy_cnt;
    int  lat;
    bit  seen;
    bit  overlap;
    Start = 1'b1;
    Data  = d;
    tick();
    Start = 1'b0;
    Data  = 16'($urandom);
    busy_cnt = 0;
    lat      = 1;
    seen     = 1'b0;
    overlap  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Done && Busy) overlap = 1'b1;
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) busy_cnt++;
      tick();
      lat++;
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(STEPS + 1));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(STEPS));
    check({name, " count"}, 32'(Count), 32'(exp));
    check({name, " done_busy_overlap"}, 32'(overlap), 32'd0);
    tick();
    check({name, " done_pulse_width"}, 32'(Done), 32'd0);
    check({name, " busy_after"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int pulses;
    bit seen;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'h0000, 5'd0};
    vecs[1] = '{16'hFFFF, 5'd16};
    vecs[2] = '{16'hA5C3, 5'd8};
    vecs[3] = '{16'h0001, 5'd1};
    vecs[4] = '{16'h8000, 5'd1};
    vecs[5] = '{16'h000F, 5'd4};
    vecs[6] = '{16'h1234, 5'd5};
    vecs[7] = '{16'hF0F0, 5'd8};

    Reset = 1'b1;
    Start = 1'b0;
    Data  = '0;
    tick();
    tick();
    Reset = 1'b0;
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset count", 32'(Count), 32'd0);

    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].data, vecs[v].cnt, $sformatf("vec%0d", v));
    end

    // Start re-asserted during RUN is ignored; held high re-triggers in first IDLE cycle.
    Start = 1'b1;
    Data  = 16'h000F;
    tick();
    Data  = 16'hFFFF;
    pulses = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Done) begin
        pulses++;
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("retrig done_seen", 32'(seen), 32'd1);
    check("retrig count", 32'(Count), 32'd4);
    tick();
    check("retrig idle busy", 32'(Busy), 32'd0);
    check("retrig idle done", 32'(Done), 32'd0);
    tick();
    check("retrig reaccept busy", 32'(Busy), 32'd1);
    Start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Done) begin
        pulses++;
        break;
      end
      tick();
    end
    check("retrig pulses", 32'(pulses), 32'd2);
    check("retrig second count", 32'(Count), 32'd16);
    tick();

    // Reset on the 2nd RUN cycle aborts with no Done.
    Start = 1'b1;
    Data  = 16'hFFFF;
    tick();
    Start = 1'b0;
    tick();
    check("abort in run", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort busy", 32'(Busy), 32'd0);
    check("abort done", 32'(Done), 32'd0);
    check("abort count", 32'(Count), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (Done) pulses++;
      tick();
    end
    check("abort no_done", 32'(pulses), 32'd0);

    // Count holds through IDLE; Start with Reset is dropped.
    run_op(16'hA5C3, 5'd8, "hold_op");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold count c%0d", i), 32'(Count), 32'd8);
      check($sformatf("hold done c%0d", i), 32'(Done), 32'd0);
      tick();
    end
    Start = 1'b1;
    Reset = 1'b1;
    Data  = 16'hFFFF;
    tick();
    Start = 1'b0;
    Reset = 1'b0;
    check("start_reset busy", 32'(Busy), 32'd0);
    check("start_reset count", 32'(Count), 32'd0);
    tick();
    check("start_reset still idle", 32'(Busy), 32'd0);
    check("start_reset no done", 32'(Done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
